pucch_re_mapper: RTL and testbench
==================================

// Module: pucch_re_mapper
// PURPOSE
//  Downstream of the PUCCH sequence generator. Takes its 12-sample-per-symbol complex stream (valid-only, no backpressure).
//  Places each symbol's 12 samples on one PRB of an N_SC-subcarrier grid and zero-fills all other subcarriers.
//  Streams one full grid row per PUCCH OFDM symbol to the IFFT input, using valid/ready.
//  A two-entry ping-pong buffer absorbs the fact that the generator cannot be stalled.
// PARAMETERS
//  N_RB    4   carrier width in PRBs; N_SC = N_RB*12 subcarriers per output row
//  SC_W    6   width of subcarrier index, >= clog2(N_SC)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  i_start      in   1   latch config, arm block (ignored unless IDLE)
//  i_start_prb  in   8   PRB of first hop (0..N_RB-1)
//  i_second_prb in   8   PRB of second hop (used only with PUCCH_FREQ_HOP_EN)
//  i_sym_start  in   4   first PUCCH OFDM symbol (0-13), reported on o_sym
//  i_n_sym      in   4   number of symbols to map (1-14)
//  i_valid      in   1   input sample strobe (generator o_valid)
//  i_re/i_im    in   16  input sample, sfix16_En15
//  o_valid      out  1   output sample valid
//  i_ready      in   1   downstream ready
//  o_re/o_im    out  16  grid sample, sfix16_En15; 0 outside the PUCCH PRB
//  o_sc         out  SC_W subcarrier index 0..N_SC-1
//  o_sym        out  4   OFDM symbol index = i_sym_start + row count
//  o_last       out  1   last subcarrier of last symbol
//  o_busy       out  1   not IDLE
//  o_overflow   out  1   sticky: input sample dropped because both buffers were full
//  o_cfg_err    out  1   pulse: i_start rejected (PRB out of range, or n_sym==0)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM IDLE; both buffers empty; counters 0.
//  Reset mid-operation clears everything immediately. The partial row is abandoned and nothing is flushed.
//  FSM states and transitions:
//   - IDLE  -> WAIT on i_start with valid config.
//   - IDLE  -> IDLE on i_start with start_prb>=N_RB, or n_sym==0 (hop build: also second_prb>=N_RB). Pulses o_cfg_err for 1 cycle.
//   - WAIT  -> OUT when the read-side buffer is full.
//   - OUT   -> WAIT after the handshake of sc=N_SC-1, if more rows remain.
//   - OUT   -> DONE after the handshake of sc=N_SC-1 on the last row.
//   - DONE  -> IDLE after 1 cycle.
//  Write side:
//   - Accepted samples fill the write buffer at addresses 0..11 and wrap to 0.
//   - The buffer is marked full on the 12th sample, then the write pointer toggles.
//   - Writes are accepted only in WAIT/OUT and only while fewer than n_sym*12 samples have been taken. Other samples are silently ignored.
//   - i_valid with both buffers full: sample dropped, o_overflow set. o_overflow clears only on rst or the next accepted i_start.
//  Read side:
//   - o_valid rises exactly 2 cycles after the 12th input sample of a row when the FSM was waiting in WAIT.
//   - Output register holds o_re/o_im/o_sc/o_sym stable while o_valid & !i_ready.
//   - o_sc advances only on o_valid & i_ready.
//   - Data = buf[o_sc - base] when base <= o_sc <= base+11, else 0; base = prb*12 (12-bit arithmetic, no wrap).
//   - The read buffer frees on the sc=N_SC-1 handshake.
//  Write and free of the same buffer in the same cycle: the free happens first and the write is accepted (no overflow).
//  o_last = o_valid & (o_sc==N_SC-1) & (last row).
// CONFIGURATION
//  PUCCH_FREQ_HOP_EN defined:
//   - intra-slot hopping. Rows 0..floor(n_sym/2)-1 use i_start_prb; the remaining rows use i_second_prb.
//   - n_sym=1: all rows on the first hop.
//  PUCCH_FREQ_HOP_EN undefined: i_second_prb is ignored and all rows use i_start_prb.
// STRUCTURE
//  pucch_pkg:
//   - typedef struct packed {logic signed [15:0] re, im;} cplx16_t
//   - localparams NRBSC=12 and N_SLOT_SYMB=14
//   - enum map_state_t {IDLE, WAIT, OUT, DONE}
//  Sub-module pucch_pingpong_buf: 2x12 cplx16_t storage, write/read pointers, full flags, overflow detect.
//  Top holds the FSM, subcarrier/row counters, PRB select and the output register.
// TESTING
//  1. Basic mapping:
//   - Stimulus: N_RB=4, start_prb=2, n_sym=1; 12 samples re=1..12, im=0, one per cycle.
//   - Response: 48 outputs; sc 24..35 = 1..12; all others 0; o_sym=sym_start; o_last on sc=47.
//  2. Backpressure:
//   - Stimulus: i_ready toggling 1/0 during output.
//   - Response: every stalled sample held stable; exactly 48 handshakes per row; no overflow.
//  3. Overflow:
//   - Stimulus: i_ready=0, n_sym=4; 36 consecutive input samples.
//   - Response: first 24 buffered; samples 25..36 dropped; o_overflow=1.
//   - Stimulus: then i_ready=1.
//   - Response: rows 0 and 1 output correctly.
//  4. Config error:
//   - Stimulus: start_prb=4 with N_RB=4.
//   - Response: o_cfg_err pulse; o_busy stays 0.
//  5. Frequency hopping (PUCCH_FREQ_HOP_EN):
//   - Stimulus: n_sym=5, start_prb=0, second_prb=3.
//   - Response: rows 0-1 data at sc 0..11; rows 2-4 data at sc 36..47.
//   - Without the macro: all 5 rows at sc 0..11.
//  6. Async reset:
//   - Stimulus: rst asserted mid-row (after sc=20).
//   - Response: o_valid=0 and o_busy=0 immediately.
//   - Stimulus: new i_start.
//   - Response: clean row from sc=0.

Source files
------------

// File: rtl/pucch_re_mapper_pkg.sv
// Shared types for the PUCCH RE mapper: complex sample, grid constants, FSM states.
package pucch_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    localparam int NRBSC       = 12;
    localparam int N_SLOT_SYMB = 14;

    typedef enum logic [1:0] {IDLE, WAIT, OUT, DONE} map_state_t;

endpackage

// File: rtl/pucch_re_mapper_buf.sv
// Two 12-sample ping-pong buffers; write side cannot stall, so a write into a full buffer is dropped and flagged.
// Combinational read of the read-side buffer; a free and a write to the same buffer in one cycle frees first.
module pucch_pingpong_buf
    import pucch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_wr_vld,
    input  cplx16_t    i_wr_dat,
    input  logic       i_free,
    input  logic [3:0] i_rd_addr,
    output cplx16_t    o_rd_dat,
    output logic       o_rd_full,
    output logic       o_wr_acc,
    output logic       o_ovf
);

    cplx16_t    r_mem [2][NRBSC];
    logic [1:0] r_full;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [3:0] r_wr_addr;
    logic       w_wr_blocked;

    // Both buffers full means the write pointer has caught up with the read pointer.
    assign w_wr_blocked = r_full[r_wr_ptr] && !(i_free && (r_rd_ptr == r_wr_ptr));
    assign o_wr_acc     = i_wr_vld && !w_wr_blocked;
    assign o_ovf        = i_wr_vld && w_wr_blocked;
    assign o_rd_full    = r_full[r_rd_ptr];
    assign o_rd_dat     = r_mem[r_rd_ptr][i_rd_addr];

    always_ff @(posedge clk) begin
        if (o_wr_acc) begin
            r_mem[r_wr_ptr][r_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_wr_addr <= '0;
        end else if (i_clr) begin
            r_full    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            if (i_free) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= !r_rd_ptr;
            end
            if (o_wr_acc) begin
                if (r_wr_addr == 4'(NRBSC - 1)) begin
                    r_wr_addr        <= '0;
                    r_full[r_wr_ptr] <= 1'b1;
                    r_wr_ptr         <= !r_wr_ptr;
                end else begin
                    r_wr_addr <= r_wr_addr + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pucch_re_mapper.sv
// Maps 12-sample PUCCH symbols onto one PRB of an N_SC grid row, zero elsewhere; valid/ready output, o_valid 2 cycles
// after a row's 12th sample when idle-waiting, held while !i_ready. PUCCH_FREQ_HOP_EN enables intra-slot hopping.
module pucch_re_mapper
    import pucch_pkg::*;
#(
    parameter int N_RB = 4,
    parameter int SC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [7:0]      i_start_prb,
    input  logic [7:0]      i_second_prb,
    input  logic [3:0]      i_sym_start,
    input  logic [3:0]      i_n_sym,
    input  logic            i_valid,
    input  logic [15:0]     i_re,
    input  logic [15:0]     i_im,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [15:0]     o_re,
    output logic [15:0]     o_im,
    output logic [SC_W-1:0] o_sc,
    output logic [3:0]      o_sym,
    output logic            o_last,
    output logic            o_busy,
    output logic            o_overflow,
    output logic            o_cfg_err
);

    localparam int N_SC  = N_RB * NRBSC;
    localparam int CNT_W = $clog2(N_SLOT_SYMB * NRBSC + 1);

    map_state_t      r_state;
    logic [7:0]      r_prb0;
    logic [7:0]      r_prb1;
    logic [3:0]      r_sym_start;
    logic [3:0]      r_n_sym;
    logic [3:0]      r_row;
    logic [CNT_W-1:0] r_cnt;
    logic            r_valid;
    logic [15:0]     r_re;
    logic [15:0]     r_im;
    logic [SC_W-1:0] r_sc;
    logic [3:0]      r_sym;
    logic            r_last;
    logic            r_ovf;
    logic            r_cfg_err;

    logic            w_cfg_bad;
    logic [7:0]      w_prb;
    logic [CNT_W-1:0] w_cnt_lim;
    logic            w_wr_vld;
    logic            w_wr_acc;
    logic            w_ovf;
    logic            w_clr;
    logic            w_hs;
    logic            w_row_end;
    logic            w_last_row;
    logic            w_rd_full;
    cplx16_t         w_wr_dat;
    cplx16_t         w_rd_dat;
    logic [SC_W-1:0] w_ld_sc;
    logic [11:0]     w_base;
    logic [11:0]     w_sc12;
    logic            w_in_prb;
    logic [3:0]      w_rd_addr;

`ifdef PUCCH_FREQ_HOP_EN
    assign w_cfg_bad = (i_start_prb >= 8'(N_RB)) || (i_second_prb >= 8'(N_RB)) || (i_n_sym == 4'd0);
    // A single-symbol allocation never hops.
    assign w_prb = ((r_n_sym > 4'd1) && (r_row >= (r_n_sym >> 1))) ? r_prb1 : r_prb0;
`else
    logic w_unused_prb;
    assign w_unused_prb = ^{i_second_prb, r_prb1};
    assign w_cfg_bad    = (i_start_prb >= 8'(N_RB)) || (i_n_sym == 4'd0);
    assign w_prb        = r_prb0;
`endif

    // Only stored samples count toward the allocation; dropped ones do not.
    assign w_cnt_lim  = CNT_W'(r_n_sym) * CNT_W'(NRBSC);
    assign w_wr_vld   = i_valid && ((r_state == WAIT) || (r_state == OUT)) && (r_cnt < w_cnt_lim);
    assign w_wr_dat   = '{re: i_re, im: i_im};
    assign w_clr      = (r_state == IDLE) && i_start && !w_cfg_bad;
    assign w_hs       = r_valid && i_ready;
    assign w_row_end  = (r_state == OUT) && w_hs && (r_sc == SC_W'(N_SC - 1));
    assign w_last_row = (r_row == r_n_sym - 4'd1);

    assign w_ld_sc   = (r_state == OUT) ? r_sc + SC_W'(1) : '0;
    assign w_base    = 12'(w_prb) * 12'(NRBSC);
    assign w_sc12    = 12'(w_ld_sc);
    assign w_in_prb  = (w_sc12 >= w_base) && (w_sc12 < w_base + 12'(NRBSC));
    assign w_rd_addr = w_in_prb ? 4'(w_sc12 - w_base) : 4'd0;

    pucch_pingpong_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_wr_vld  (w_wr_vld),
        .i_wr_dat  (w_wr_dat),
        .i_free    (w_row_end),
        .i_rd_addr (w_rd_addr),
        .o_rd_dat  (w_rd_dat),
        .o_rd_full (w_rd_full),
        .o_wr_acc  (w_wr_acc),
        .o_ovf     (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prb0      <= '0;
            r_prb1      <= '0;
            r_sym_start <= '0;
            r_n_sym     <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_re        <= '0;
            r_im        <= '0;
            r_sc        <= '0;
            r_sym       <= '0;
            r_last      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_wr_acc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_prb0      <= i_start_prb;
                            r_prb1      <= i_second_prb;
                            r_sym_start <= i_sym_start;
                            r_n_sym     <= i_n_sym;
                            r_row       <= '0;
                            r_cnt       <= '0;
                            r_ovf       <= 1'b0;
                            r_state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_rd_full) begin
                        r_state <= OUT;
                        r_valid <= 1'b1;
                        r_sc    <= w_ld_sc;
                        r_sym   <= r_sym_start + r_row;
                        r_re    <= w_in_prb ? w_rd_dat.re : '0;
                        r_im    <= w_in_prb ? w_rd_dat.im : '0;
                        r_last  <= w_last_row && (w_ld_sc == SC_W'(N_SC - 1));
                    end
                end
                OUT: begin
                    if (w_row_end) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_row   <= r_row + 4'd1;
                        r_state <= w_last_row ? DONE : WAIT;
                    end else if (w_hs) begin
                        r_sc   <= w_ld_sc;
                        r_re   <= w_in_prb ? w_rd_dat.re : '0;
                        r_im   <= w_in_prb ? w_rd_dat.im : '0;
                        r_last <= w_last_row && (w_ld_sc == SC_W'(N_SC - 1));
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_re       = r_re;
    assign o_im       = r_im;
    assign o_sc       = r_sc;
    assign o_sym      = r_sym;
    assign o_last     = r_last;
    assign o_busy     = (r_state != IDLE);
    assign o_overflow = r_ovf;
    assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_pucch_re_mapper.sv
// Directed bench for pucch_re_mapper: table of mapping vectors plus hand-written latency, overflow, config and reset cases.
module tb_pucch_re_mapper;

    localparam int N_RB = 4;
    localparam int SC_W = 6;
    localparam int N_SC = N_RB * 12;

    logic            clk;
    logic            rst;
    logic            i_start;
    logic [7:0]      i_start_prb;
    logic [7:0]      i_second_prb;
    logic [3:0]      i_sym_start;
    logic [3:0]      i_n_sym;
    logic            i_valid;
    logic [15:0]     i_re;
    logic [15:0]     i_im;
    logic            o_valid;
    logic            i_ready;
    logic [15:0]     o_re;
    logic [15:0]     o_im;
    logic [SC_W-1:0] o_sc;
    logic [3:0]      o_sym;
    logic            o_last;
    logic            o_busy;
    logic            o_overflow;
    logic            o_cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] prb_a;
        logic [7:0] prb_b;
        logic [3:0] n_sym;
        logic [3:0] sym_start;
        bit         toggle;
        int         base_a;
        int         base_b;
        int         split;
    } vec_t;

    pucch_re_mapper #(.N_RB(N_RB), .SC_W(SC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_start_prb  (i_start_prb),
        .i_second_prb (i_second_prb),
        .i_sym_start  (i_sym_start),
        .i_n_sym      (i_n_sym),
        .i_valid      (i_valid),
        .i_re         (i_re),
        .i_im         (i_im),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_re         (o_re),
        .o_im         (o_im),
        .o_sc         (o_sc),
        .o_sym        (o_sym),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_cfg_err    (o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int pa, input int pb, input int ns, input int ss, input bit tg,
                                input int ba, input int bb, input int sp);
        vec_t v;
        v.prb_a     = 8'(pa);
        v.prb_b     = 8'(pb);
        v.n_sym     = 4'(ns);
        v.sym_start = 4'(ss);
        v.toggle    = tg;
        v.base_a    = ba;
        v.base_b    = bb;
        v.split     = sp;
        return v;
    endfunction

    task automatic do_start(input vec_t v);
        @(negedge clk);
        i_start      = 1'b1;
        i_start_prb  = v.prb_a;
        i_second_prb = v.prb_b;
        i_n_sym      = v.n_sym;
        i_sym_start  = v.sym_start;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Row r, sample k carries re = r*16 + k + 1, im = r.
    task automatic send_rows(input int nrows, input int gap);
        for (int r = 0; r < nrows; r++) begin
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                i_valid = 1'b1;
                i_re    = 16'(r * 16 + k + 1);
                i_im    = 16'(r);
            end
            if (gap > 0) begin
                @(negedge clk);
                i_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic collect(input vec_t v, input int nrows);
        int          row = 0;
        int          idx = 0;
        int          cyc = 0;
        int          base;
        bit          in_prb;
        bit          rdy;
        bit          stalled = 1'b0;
        logic [63:0] held = '0;
        logic [63:0] cur;
        logic [63:0] exp_v;
        logic [15:0] ere;
        logic [15:0] eim;
        logic        elast;
        while (row < nrows && cyc < nrows * 300 + 200) begin
            @(negedge clk);
            cyc++;
            cur = {21'd0, o_sc, o_sym, o_re, o_im, o_valid};
            if (stalled) chk("stall_hold", cur, held);
            rdy     = v.toggle ? cyc[0] : 1'b1;
            i_ready = rdy;
            stalled = 1'b0;
            if (o_valid) begin
                if (rdy) begin
                    base   = (row < v.split) ? v.base_a : v.base_b;
                    in_prb = (idx >= base) && (idx < base + 12);
                    ere    = in_prb ? 16'(row * 16 + idx - base + 1) : 16'd0;
                    eim    = in_prb ? 16'(row) : 16'd0;
                    elast  = (idx == N_SC - 1) && (row == int'(v.n_sym) - 1);
                    exp_v  = {21'd0, 6'(idx), 4'(int'(v.sym_start) + row), ere, eim, elast};
                    chk("sample", {21'd0, o_sc, o_sym, o_re, o_im, o_last}, exp_v);
                    idx++;
                    if (idx == N_SC) begin
                        idx = 0;
                        row++;
                    end
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end
        end
        chk("collect_rows_done", 64'(row), 64'(nrows));
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    vec_t vt[5];
    vec_t v1;
    vec_t v3;
    vec_t v6;
    bit   hit;

    initial begin
        bit hop;
`ifdef PUCCH_FREQ_HOP_EN
        hop = 1'b1;
`else
        hop = 1'b0;
`endif
        vt[0] = mk(0, 0, 2, 0, 1'b1, 0, 0, 99);
        vt[1] = mk(3, 3, 3, 11, 1'b1, 36, 36, 99);
        vt[2] = mk(1, 1, 1, 2, 1'b0, 12, 12, 99);
        vt[3] = mk(0, 3, 5, 0, 1'b0, 0, hop ? 36 : 0, hop ? 2 : 99);
        vt[4] = mk(1, 3, 1, 7, 1'b1, 12, 36, 99);

        rst = 1'b1; i_start = 1'b0; i_start_prb = '0; i_second_prb = '0;
        i_sym_start = '0; i_n_sym = '0; i_valid = 1'b0; i_re = '0; i_im = '0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_valid, o_busy, o_overflow, o_cfg_err, o_last, o_sc, o_sym, o_re, o_im},
            64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(o_busy), 64'd0);

        // Basic mapping with exact first-output latency, output initially stalled.
        v1 = mk(2, 0, 1, 3, 1'b0, 24, 24, 99);
        do_start(v1);
        chk("busy_after_start", 64'(o_busy), 64'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_re    = 16'(k + 1);
            i_im    = 16'd0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        chk("latency_cyc1_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        chk("latency_cyc2_valid", {o_valid, o_sc}, {1'b1, 6'd0});
        collect(v1, 1);
        repeat (3) @(negedge clk);
        chk("basic_idle", {o_busy, o_overflow}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            do_start(vt[i]);
            fork
                send_rows(int'(vt[i].n_sym), 100);
                collect(vt[i], int'(vt[i].n_sym));
            join
            repeat (3) @(negedge clk);
            chk("vec_end_idle", {o_busy, o_overflow, o_valid}, 64'd0);
        end

        // Overflow: 36 back-to-back samples with output stalled.
        v3 = mk(1, 1, 4, 0, 1'b0, 12, 12, 99);
        i_ready = 1'b0;
        do_start(v3);
        send_rows(3, 0);
        @(negedge clk);
        chk("ovf_flag", 64'(o_overflow), 64'd1);
        chk("ovf_row0_held", {o_valid, o_sc, o_re}, {1'b1, 6'd0, 16'd0});
        collect(v3, 2);
        chk("ovf_wait_more", {o_busy, o_valid, o_overflow}, {1'b1, 1'b0, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ovf_cleared_by_rst", {o_busy, o_overflow}, 64'd0);

        // Config errors.
        do_start(mk(4, 0, 1, 0, 1'b0, 0, 0, 99));
        chk("cfg_err_prb", {o_cfg_err, o_busy}, {1'b1, 1'b0});
        @(negedge clk);
        chk("cfg_err_pulse_end", {o_cfg_err, o_busy}, 64'd0);
        do_start(mk(0, 0, 0, 0, 1'b0, 0, 0, 99));
        chk("cfg_err_nsym0", {o_cfg_err, o_busy}, {1'b1, 1'b0});

        // Asynchronous reset mid-row, then a clean restart.
        v6 = mk(0, 0, 1, 5, 1'b0, 0, 0, 99);
        do_start(v6);
        i_ready = 1'b1;
        send_rows(1, 0);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (o_valid && o_sc == 6'd21) hit = 1'b1;
        end
        chk("reached_sc21", 64'(hit), 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_immediate", {o_valid, o_busy, o_sc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b0;
        do_start(v6);
        fork
            send_rows(1, 0);
            collect(v6, 1);
        join
        repeat (3) @(negedge clk);
        chk("restart_idle", {o_busy, o_overflow}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
